// File: rtl/pwm_capture_5khz.sv
// PWM capture: measures high time and period of a 5 kHz PWM line in ticks.
// Optional glitch filter enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture_5khz #(
    parameter int PRESCALE  = 12,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 255,
    parameter int FULL_DUTY = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(FULL_DUTY);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic             sync1_q, sync2_q;
    logic [PW-1:0]    presc_q, presc_d;
    logic             s_prev_q, s_prev_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;

    logic             s;
    logic             m;
    logic             tick;
    logic             rise;
    logic [CNT_W-1:0] high_inc;

    assign s    = sync2_q;
    assign tick = ena && (presc_q == PS_LAST);
    assign rise = tick && m && !s_prev_q;

    // Two-flop synchronizer for the asynchronous pad input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    logic [1:0] hist_q, hist_d;
    logic       filt_q, filt_d;

    // Level only follows s once three consecutive tick samples agree.
    assign m = (s == hist_q[0] && s == hist_q[1]) ? s : filt_q;

    // Filter history advances one sample per tick.
    always_comb begin
        hist_d = hist_q;
        filt_d = filt_q;
        if (tick) begin
            hist_d = {hist_q[0], s};
            filt_d = m;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end
`else
    assign m = s;
`endif

    assign high_inc = {{(CNT_W-1){1'b0}}, m};

    // Prescaler, edge/timeout measurement and result update.
    always_comb begin
        presc_d  = presc_q;
        s_prev_d = s_prev_q;
        armed_d  = armed_q;
        per_d    = per_q;
        high_d   = high_q;
        duty_d   = duty_q;
        period_d = period_q;
        stuck_d  = stuck_q;
        valid_d  = 1'b0;
        if (!ena) begin
            presc_d  = '0;
            s_prev_d = 1'b0;
            armed_d  = 1'b0;
            per_d    = '0;
            high_d   = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                s_prev_d = m;
                if (rise) begin
                    if (armed_q) begin
                        duty_d   = high_q;
                        period_d = per_q;
                        valid_d  = 1'b1;
                        stuck_d  = 1'b0;
                    end
                    armed_d = 1'b1;
                    per_d   = ONE;
                    high_d  = ONE;
                end else begin
                    per_d  = (per_q == CNT_MAX) ? CNT_MAX : per_q + ONE;
                    high_d = (high_q == CNT_MAX) ? CNT_MAX
                                                 : high_q + high_inc;
                    // One report per stuck episode; counters keep saturating.
                    if (per_q == TO_LAST && !stuck_q) begin
                        duty_d   = m ? FULL : '0;
                        period_d = '0;
                        stuck_d  = 1'b1;
                        valid_d  = 1'b1;
                        armed_d  = 1'b0;
                    end
                end
            end
        end
    end

    // Measurement state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q  <= '0;
            s_prev_q <= 1'b0;
            armed_q  <= 1'b0;
            per_q    <= '0;
            high_q   <= '0;
            duty_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            s_prev_q <= s_prev_d;
            armed_q  <= armed_d;
            per_q    <= per_d;
            high_q   <= high_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
        end
    end

    assign duty   = duty_q;
    assign period = period_q;
    assign valid  = valid_q;
    assign stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_capture_5khz.sv
// Directed bench for pwm_capture_5khz with an expected-result queue.
// Glitch expectations follow PWM_CAP_FILTER_EN.
module tb_pwm_capture_5khz;

    localparam int P = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b1;
    logic       pwm_in = 1'b0;
    logic [7:0] duty;
    logic [7:0] period;
    logic       valid;
    logic       stuck;

    typedef struct {
        int d;
        int p;
        int s;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   last_h = 0;

    pwm_capture_5khz dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .pwm_in (pwm_in),
        .duty   (duty),
        .period (period),
        .valid  (valid),
        .stuck  (stuck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push(input int d, input int p, input int s);
        exp_t e;
        e.d = d;
        e.p = p;
        e.s = s;
        sb.push_back(e);
    endtask

    task automatic hold(input logic v, input int ticks);
        pwm_in = v;
        repeat (ticks * P) @(posedge clk);
        #1;
    endtask

    task automatic pwm_period(input int h, input bit rep);
        if (rep) push(last_h, 200, 0);
        hold(1'b1, h);
        hold(1'b0, 200 - h);
        last_h = h;
    endtask

    // Every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("duty", int'(duty), e.d);
                chk("period", int'(period), e.p);
                chk("stuck", int'(stuck), e.s);
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_duty", int'(duty), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_stuck", int'(stuck), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Line low from reset: timeout reports stuck low
        push(0, 0, 1);
        hold(1'b0, 270);
        chk("stuck_lo", int'(stuck), 1);
        chk("stuck_lo_duty", int'(duty), 0);

        // Recovery: first edge arms, second edge reports
        pwm_period(100, 0);
        pwm_period(100, 1);
        chk("recover_stuck", int'(stuck), 0);

        // Steady duty 50, then change to 150
        pwm_period(50, 1);
        pwm_period(50, 1);
        pwm_period(50, 1);
        pwm_period(150, 1);
        pwm_period(150, 1);

        // Line held high: last period reported, then stuck high once
        push(last_h, 200, 0);
        push(200, 0, 1);
        hold(1'b1, 275);
        chk("stuck_hi", int'(stuck), 1);
        chk("stuck_hi_duty", int'(duty), 200);
        chk("stuck_hi_period", int'(period), 0);
        hold(1'b0, 100);

        // Resume with duty 100
        pwm_period(100, 0);
        pwm_period(100, 1);

        // Reset pulse in the low phase
        push(last_h, 200, 0);
        hold(1'b1, 100);
        hold(1'b0, 50);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_duty", int'(duty), 0);
        chk("midrst_period", int'(period), 0);
        chk("midrst_valid", int'(valid), 0);
        rst = 1'b1;
        hold(1'b0, 50);
        chk("postrst_stuck", int'(stuck), 0);
        pwm_period(100, 0);
        pwm_period(100, 1);

        // ena low for a full period: outputs hold
        push(last_h, 200, 0);
        hold(1'b1, 100);
        hold(1'b0, 50);
        ena = 1'b0;
        hold(1'b0, 50);
        chk("ena_duty", int'(duty), 100);
        chk("ena_period", int'(period), 200);
        chk("ena_stuck", int'(stuck), 0);
        chk("ena_valid", int'(valid), 0);
        hold(1'b1, 100);
        hold(1'b0, 50);
        ena = 1'b1;
        hold(1'b0, 50);
        pwm_period(100, 0);
        pwm_period(100, 1);

        // One-tick glitch in the low phase, duty 80
        push(last_h, 200, 0);
        hold(1'b1, 80);
        hold(1'b0, 60);
`ifdef PWM_CAP_FILTER_EN
        hold(1'b1, 1);
        hold(1'b0, 59);
        push(80, 200, 0);
`else
        push(80, 140, 0);
        hold(1'b1, 1);
        hold(1'b0, 59);
        push(1, 60, 0);
`endif
        hold(1'b1, 80);
        hold(1'b0, 120);

        chk("sb_empty", sb.size(), 0);
        chk("end_stuck", int'(stuck), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
